// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM encoding and oversampling constants.
// PARITY state encoding only exists when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int OVS       = 16;
  localparam int MID       = 8;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample timebase: tick_o is high for one clock every OVS_DIV clocks.
// Not realigned to frame edges; the receiver tolerates the resulting sub-tick phase error.
module uart_rx_tick #(
  parameter int unsigned OVS_DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = (cnt_q == 16'(OVS_DIV - 1));
  assign cnt_d  = tick_o ? 16'd0 : cnt_q + 16'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1/8O1 with UART_RX_PARITY_EN): 2-flop sync, 16x oversample, mid-bit sampling.
// rx_valid_o/rx_ferr_o strobe one clock after the mid-stop tick; no buffering, consumer must take data on the strobe.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS_DIV    = 27,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_pin_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_perr_o,
  output logic       rx_busy_o
);

  logic       sync_q;
  logic       rx_s_q;
  logic       tick;
  rx_state_e  state_q;
  logic [3:0] sub_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       ferr_q;
  logic       mid_start;
  logic       mid_bit;

`ifdef UART_RX_PARITY_EN
  logic perr_flag_q;
  logic perr_q;
`endif

  uart_rx_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  // Reset to idle-high so a reset can never look like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= rx_pin_i;
      rx_s_q <= sync_q;
    end
  end

  assign mid_start = (sub_q == 4'(MID - 1));
  assign mid_bit   = (sub_q == 4'(OVS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sub_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_flag_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (tick) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!rx_s_q) begin
              state_q <= ST_START;
              sub_q   <= 4'd0;
            end
          end
          ST_START: begin
            if (mid_start) begin
              sub_q   <= 4'd0;
              bit_q   <= 3'd0;
              state_q <= rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
              sub_q <= sub_q + 4'd1;
            end
          end
          ST_DATA: begin
            // sub_q wraps 15 -> 0, so every state after START samples on the same phase.
            sub_q <= sub_q + 4'd1;
            if (mid_bit) begin
              shift_q <= {rx_s_q, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            sub_q <= sub_q + 4'd1;
            if (mid_bit) begin
              perr_flag_q <= rx_s_q ^ (^shift_q) ^ PARITY_ODD;
              state_q     <= ST_STOP;
            end
          end
`endif
          ST_STOP: begin
            sub_q <= sub_q + 4'd1;
            if (mid_bit) begin
              if (rx_s_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_q  <= perr_flag_q;
`endif
                state_q <= ST_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
              end
            end
          end
          ST_BREAK: begin
            if (rx_s_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_ferr_o  = ferr_q;
  assign rx_busy_o  = (state_q != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign rx_perr_o = perr_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign rx_perr_o         = 1'b0;
`endif

endmodule
